// File: rtl/ps2_arrow_decoder_if.sv
// rtl/ps2_arrow_decoder_if.sv - scancode input, held-key levels and move-event handshake
interface ps2_arrow_decoder_if;
   logic [7:0] ps2_key_data;
   logic       ps2_key_pressed;
   logic       up;
   logic       down;
   logic       left;
   logic       right;
   logic       ev_valid;
   logic [1:0] ev_dir;
   logic       ev_ready;
   logic       ev_drop;

   modport master (
      output ps2_key_data, ps2_key_pressed, ev_ready,
      input  up, down, left, right, ev_valid, ev_dir, ev_drop
   );

   modport slave (
      input  ps2_key_data, ps2_key_pressed, ev_ready,
      output up, down, left, right, ev_valid, ev_dir, ev_drop
   );
endinterface

// File: rtl/ps2_arrow_decoder.sv
// rtl/ps2_arrow_decoder.sv - PS/2 make/break/E0 parser producing arrow/WASD levels and move events
module ps2_arrow_decoder #(
   parameter int TIMEOUT_CYCLES = 500000,
   parameter int REPEAT_CYCLES  = 5000000,
   parameter int WASD_EN        = 1
) (
   input logic           clock,
   input logic           reset,
   ps2_arrow_decoder_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] REP_LAST = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
   localparam bit REP_EN = (REPEAT_CYCLES > 0);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [TW-1:0] r_to_cnt;
   logic [RW-1:0] r_rep_cnt;
   logic [3:0]    r_lvl;
   logic          r_last_vld;
   logic [1:0]    r_last_dir;
   logic          r_ev_valid;
   logic [1:0]    r_ev_dir;
   logic          r_ev_drop;

   logic       w_stb;
   logic [7:0] w_byte;
   logic       w_is_e0;
   logic       w_is_f0;
   logic       w_to_hit;
   logic       w_key_act;
   logic       w_key_brk;
   logic       w_key_ext;
   logic       w_hit;
   logic [1:0] w_dir;
   logic       w_make_ev;
   logic       w_brk_hit;
   logic       w_rep_ev;
   logic       w_gen;
   logic [1:0] w_gen_dir;

   assign w_stb    = bus.ps2_key_pressed;
   assign w_byte   = bus.ps2_key_data;
   assign w_is_e0  = (w_byte == 8'hE0);
   assign w_is_f0  = (w_byte == 8'hF0);
   assign w_to_hit = (r_state != S_IDLE) && !w_stb && (r_to_cnt == TO_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_stb) begin
         case (r_state)
            S_IDLE:  w_state_nxt = w_is_e0 ? S_EXT : (w_is_f0 ? S_BRK : S_IDLE);
            S_EXT:   w_state_nxt = w_is_f0 ? S_EXT_BRK : (w_is_e0 ? S_EXT : S_IDLE);
            default: w_state_nxt = S_IDLE;
         endcase
      end else if (w_to_hit) begin
         w_state_nxt = S_IDLE;
      end
   end

   // Key action: which strobe completes a make or break, and whether it was E0-prefixed
   always_comb begin
      w_key_act = 1'b0;
      w_key_brk = 1'b0;
      w_key_ext = 1'b0;
      if (w_stb) begin
         case (r_state)
            S_IDLE:    w_key_act = !w_is_e0 && !w_is_f0;
            S_EXT: begin
               w_key_act = !w_is_e0 && !w_is_f0;
               w_key_ext = 1'b1;
            end
            S_BRK:     w_key_brk = 1'b1;
            S_EXT_BRK: begin
               w_key_brk = 1'b1;
               w_key_ext = 1'b1;
            end
            default: ;
         endcase
         if (r_state == S_BRK || r_state == S_EXT_BRK) w_key_act = 1'b1;
      end
   end

   always_comb begin
      w_hit = 1'b0;
      w_dir = 2'd0;
      if (w_key_ext) begin
         case (w_byte)
            8'h75: begin w_hit = 1'b1; w_dir = 2'd0; end
            8'h72: begin w_hit = 1'b1; w_dir = 2'd1; end
            8'h6B: begin w_hit = 1'b1; w_dir = 2'd2; end
            8'h74: begin w_hit = 1'b1; w_dir = 2'd3; end
            default: ;
         endcase
      end else if (WASD_EN != 0) begin
         case (w_byte)
            8'h1D: begin w_hit = 1'b1; w_dir = 2'd0; end
            8'h1B: begin w_hit = 1'b1; w_dir = 2'd1; end
            8'h1C: begin w_hit = 1'b1; w_dir = 2'd2; end
            8'h23: begin w_hit = 1'b1; w_dir = 2'd3; end
            default: ;
         endcase
      end
   end

   assign w_make_ev = w_key_act && w_hit && !w_key_brk && !r_lvl[w_dir];
   assign w_brk_hit = w_key_act && w_hit && w_key_brk;
   // A break of the last key in the same cycle as its repeat point suppresses that repeat
   assign w_rep_ev  = REP_EN && r_last_vld && (r_rep_cnt == REP_LAST) &&
                      !(w_brk_hit && (w_dir == r_last_dir));
   assign w_gen     = w_make_ev || w_rep_ev;
   assign w_gen_dir = w_make_ev ? w_dir : r_last_dir;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_to_cnt <= '0;
      end else if (r_state == S_IDLE || w_stb || w_to_hit) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_lvl      <= 4'b0000;
         r_last_vld <= 1'b0;
         r_last_dir <= 2'd0;
         r_rep_cnt  <= '0;
      end else if (w_make_ev) begin
         r_lvl[w_dir] <= 1'b1;
         r_last_vld   <= 1'b1;
         r_last_dir   <= w_dir;
         r_rep_cnt    <= '0;
      end else begin
         if (w_brk_hit) begin
            r_lvl[w_dir] <= 1'b0;
            if (r_last_vld && (r_last_dir == w_dir)) r_last_vld <= 1'b0;
         end
         if (REP_EN && r_last_vld) r_rep_cnt <= (r_rep_cnt == REP_LAST) ? '0 : r_rep_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ev_valid <= 1'b0;
         r_ev_dir   <= 2'd0;
         r_ev_drop  <= 1'b0;
      end else begin
         r_ev_drop <= 1'b0;
         if (w_gen) begin
            r_ev_valid <= 1'b1;
            r_ev_dir   <= w_gen_dir;
            r_ev_drop  <= r_ev_valid && !bus.ev_ready;
         end else if (r_ev_valid && bus.ev_ready) begin
            r_ev_valid <= 1'b0;
         end
      end
   end

   assign bus.up       = r_lvl[0];
   assign bus.down     = r_lvl[1];
   assign bus.left     = r_lvl[2];
   assign bus.right    = r_lvl[3];
   assign bus.ev_valid = r_ev_valid;
   assign bus.ev_dir   = r_ev_dir;
   assign bus.ev_drop  = r_ev_drop;
endmodule

// File: doc/ps2_arrow_decoder.md
# ps2_arrow_decoder

- Converts the raw PS/2 byte stream from `PS2_Interface` (`ps2_key_data`, `ps2_key_pressed`) into direction information for the VGA game logic.
- Parses make, break (F0) and extended (E0) prefixes, and maintains held-key levels for up/down/left/right.
- Emits discrete move events with internal auto-repeat over a valid/ready handshake.
- Sits between the keyboard controller and `vga_controller`; its level outputs drive the `left/right/up/down` inputs.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 500000, max idle cycles inside a prefix sequence before abandoning it (>=1)
- `REPEAT_CYCLES`, 5000000, auto-repeat period while the last-pressed direction is held; 0 disables repeat
- `WASD_EN`, 1, also map W/S/A/D (1D/1B/1C/23) to up/down/left/right

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clock`  in  1  system clock (CLOCK_50 domain)
  - `reset`  in  1  asynchronous, active-high
- Input stream:
  - `ps2_key_data`  in  8  received scancode byte, valid when strobe high
  - `ps2_key_pressed`  in  1  one-cycle strobe per received byte
- Held-key levels:
  - `up`, `down`, `left`, `right`  out  1 each  held-key levels
- Move-event handshake:
  - `ev_valid`  out  1  move event pending
  - `ev_dir`  out  2  00 up, 01 down, 10 left, 11 right
  - `ev_ready`  in  1  consumer accepts event when `ev_valid & ev_ready`
  - `ev_drop`  out  1  one-cycle pulse: pending unaccepted event overwritten

## Operation
- Parser FSM states: IDLE, EXT, BRK, EXT_BRK. It advances only on a strobe (or a timeout).
  - IDLE:
    - E0 -> EXT
    - F0 -> BRK
    - other byte -> non-extended make; stay IDLE
  - EXT:
    - F0 -> EXT_BRK
    - E0 -> EXT
    - other -> extended make; -> IDLE
  - BRK: any byte -> non-extended break of that byte; -> IDLE.
  - EXT_BRK: any byte -> extended break; -> IDLE.
- Key map:
  - Extended: 75 up, 72 down, 6B left, 74 right.
  - Non-extended: WASD codes, only when `WASD_EN=1`.
  - Unmapped codes change nothing except FSM state.
- Make of a mapped key:
  - Sets its level.
  - If the level was already 1 (keyboard typematic), nothing else happens.
  - Otherwise it becomes the "last key", restarts the repeat counter at 0, and generates an event.
- Break of a mapped key:
  - Clears its level.
  - If it is the last key, repeat stops. Other held keys do not resume repeat.
- Opposing keys may both be held; levels are reported as-is.
- Auto-repeat: while the last key is held and `REPEAT_CYCLES>0`, the counter increments every cycle. At `REPEAT_CYCLES-1` it generates an event for the last key and wraps to 0.
- Timeout: in any non-IDLE state the counter counts cycles without a strobe. On reaching `TIMEOUT_CYCLES` the FSM returns to IDLE with no key effect. Each strobe clears the counter.
- Event register (single entry):
  - A generated event loads `ev_dir` and sets `ev_valid`.
  - Accept (`ev_valid & ev_ready`) with no new event clears `ev_valid`.
  - New event while valid and not accepted: overwrite and pulse `ev_drop`.
  - Accept and new event in the same cycle: load new, `ev_valid` stays 1, no drop.
  - Make event and repeat event in the same cycle: the make event wins.

## Timing
- Reset values:
  - FSM = IDLE.
  - `up`, `down`, `left`, `right` = 0; `ev_valid` = 0, `ev_dir` = 00, `ev_drop` = 0.
  - Counters = 0; no last key.
- Reset mid-sequence or mid-hold discards all state immediately (asynchronous).
- Latency:
  - Strobe with the final byte in cycle n -> levels and `ev_valid` updated at edge n+1.
  - `ev_valid` drops at the edge after acceptance.
- Repeat events are spaced exactly `REPEAT_CYCLES` cycles apart. The first repeat comes `REPEAT_CYCLES` cycles after the make event.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
Benches run with `TIMEOUT_CYCLES=8`, `REPEAT_CYCLES=16`, `WASD_EN=1`.
- Press then release up:
  - Stimulus: bytes E0,75 with `ev_ready=1`, then E0,F0,75.
  - Response: `up`=1 one cycle after the 75 strobe; single `ev_valid` pulse with `ev_dir`=00; `up`=0 after the final 75.
- Typematic and repeat:
  - Stimulus: E0,6B, then E0,6B again 5 cycles later, held 40 cycles.
  - Response: one make event only; repeat events with `ev_dir`=10 at +16 and +32 cycles.
- Prefix timeout:
  - Stimulus: E0, then 9 idle cycles, then 75.
  - Response: FSM back at IDLE by cycle 8; 75 treated as non-extended (unmapped); `up` stays 0, no event.
- Backpressure:
  - Stimulus: `ev_ready=0`; press W then D.
  - Response: `ev_dir`=11, `ev_drop` pulses once. Then raise `ev_ready` together with an A press: `ev_valid` stays 1, `ev_dir`=10, no drop.
- Release of last key:
  - Stimulus: hold left, then right, release right.
  - Response: `left`=1, `right`=0, no further repeat events.
- Async reset:
  - Stimulus: assert `reset` mid E0,F0 with `down` held and an event pending.
  - Response: all outputs 0 immediately; the next byte 72 produces no break effect.
